// File: rtl/nv_ram_rwsthp_20x16_fifo_ctrl_if.sv
// rtl/nv_ram_rwsthp_20x16_fifo_ctrl_if.sv - write/read stream handshake bundle for the RAM FIFO controller
// master = producer/consumer side, slave = controller side.
interface nv_ram_rwsthp_20x16_fifo_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );
endinterface

// File: rtl/nv_ram_rwsthp_20x16_fifo_ctrl.sv
// rtl/nv_ram_rwsthp_20x16_fifo_ctrl.sv - valid/ready FIFO controller driving one nv_ram_rwsthp_20x16
// Define FIFO_BYPASS_EN to let a word arriving at an empty FIFO skip the RAM straight into its output register.
module nv_ram_rwsthp_20x16_fifo_ctrl #(
  parameter int DEPTH = 20,
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  nv_ram_rwsthp_20x16_fifo_ctrl_if.slave s,
  output logic [AW-1:0]        ram_wa,
  output logic                 ram_we,
  output logic [WIDTH-1:0]     ram_di,
  output logic [AW-1:0]        ram_ra,
  output logic                 ram_re,
  output logic                 ram_ore,
  output logic                 ram_byp_sel,
  output logic [WIDTH-1:0]     ram_dbyp,
  input  logic [WIDTH-1:0]     ram_dout,
  output logic [4:0]           cnt
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [4:0]    FULL_CNT = 5'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    avail_q, avail_d;
  logic          s1_vld_q, s1_vld_d;
  logic          out_vld_q, out_vld_d;
  logic          wr_prdy_q, wr_prdy_d;
  logic          byp, push, ore, re, free;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef FIFO_BYPASS_EN
  assign byp = !rst && s.wr_pvld && (cnt_q == 5'd0) && (avail_q == 5'd0) && !s1_vld_q &&
               (!out_vld_q || s.rd_prdy);
`else
  assign byp = 1'b0;
`endif

  // All RAM strobes are forced low during reset so a reset cycle never disturbs RAM contents or pipeline.
  assign push = !rst && s.wr_pvld && wr_prdy_q && !byp;
  assign ore  = !rst && (s1_vld_q || byp) && (!out_vld_q || s.rd_prdy);
  assign re   = !rst && (avail_q != 5'd0) && (!s1_vld_q || ore);
  assign free = ore && s1_vld_q;

  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d     = cnt_q;
    avail_d   = avail_q;
    if (push && !free) cnt_d = cnt_q + 5'd1;
    else if (!push && free) cnt_d = cnt_q - 5'd1;
    if (push && !re) avail_d = avail_q + 5'd1;
    else if (!push && re) avail_d = avail_q - 5'd1;
    s1_vld_d  = re || (s1_vld_q && !ore);
    out_vld_d = ore || (out_vld_q && !s.rd_prdy);
    wr_prdy_d = (cnt_d < FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      avail_q   <= '0;
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      wr_prdy_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      avail_q   <= avail_d;
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
      wr_prdy_q <= wr_prdy_d;
    end
  end

  assign ram_we      = push;
  assign ram_wa      = wr_ptr_q;
  assign ram_di      = s.wr_pd;
  assign ram_re      = re;
  assign ram_ra      = rd_ptr_q;
  assign ram_ore     = ore;
  assign ram_byp_sel = byp;
  assign ram_dbyp    = s.wr_pd;
  assign s.rd_pd     = ram_dout;
  assign s.rd_pvld   = out_vld_q;
  assign s.wr_prdy   = wr_prdy_q;
  assign cnt         = cnt_q;

endmodule

// File: tb/tb_nv_ram_rwsthp_20x16_fifo_ctrl.sv
// tb/tb_nv_ram_rwsthp_20x16_fifo_ctrl.sv - scoreboard bench for the RAM FIFO controller with a behavioural RAM
// Honours FIFO_BYPASS_EN for the expected write-to-read latency.
module tb_nv_ram_rwsthp_20x16_fifo_ctrl;

`ifdef FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif
  localparam int CAP = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ram_wa, ram_ra, cnt;
  logic        ram_we, ram_re, ram_ore, ram_byp_sel;
  logic [15:0] ram_di, ram_dbyp, ram_dout;

  nv_ram_rwsthp_20x16_fifo_ctrl_if #(.WIDTH(16)) bus ();

  nv_ram_rwsthp_20x16_fifo_ctrl dut (
    .clk(clk), .rst(rst), .s(bus.slave),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp),
    .ram_dout(ram_dout), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Behavioural two-stage RAM: re latches address, ore loads dout from the latched address or bypass.
  logic [15:0] mem [0:19];
  logic [4:0]  ra_lat;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_lat <= ram_ra;
    if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_lat];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted writes enter the queue, delivered reads must match its head.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (bus.wr_pvld && bus.wr_prdy) exp_q.push_back(bus.wr_pd);
        if (bus.rd_pvld && bus.rd_prdy) begin
          rd_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got %0h expected no data", bus.rd_pd);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data", {16'h0, bus.rd_pd}, {16'h0, e});
          end
        end
        chk("cnt_le_20", {31'h0, (cnt <= 5'd20)}, 32'd1);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = d;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_prdy) ok = 1'b1;
      tick();
    end
    bus.wr_pvld = 1'b0;
  endtask

  task automatic drain();
    bus.rd_prdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_q.size() == 0 && !bus.rd_pvld) break;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_rd_pvld", {31'h0, bus.rd_pvld}, 0);
  endtask

  // toggle: rd_prdy flips every cycle with random write gaps; otherwise both sides run flat out.
  task automatic stream(input int n, input bit toggle);
    int sent = 0;
    logic [15:0] d = 16'($urandom);
    for (int c = 0; c < 3000 && sent < n; c++) begin
      bus.rd_prdy = toggle ? ~bus.rd_prdy : 1'b1;
      bus.wr_pvld = toggle ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.wr_pd   = d;
      @(negedge clk);
      if (!toggle) chk("full_cnt_hold", {31'h0, (cnt >= 5'd19 && cnt <= 5'd20)}, 1);
      if (bus.wr_pvld && bus.wr_prdy) begin
        sent++;
        d = 16'($urandom);
      end
      tick();
    end
    bus.wr_pvld = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic fill(output int acc);
    bit ok;
    acc = 0;
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 23; i++) begin
      write_word(16'(i), ok);
      if (!ok) break;
      acc++;
    end
  endtask

  initial begin
    int pulses, n, acc, gaps, r0;
    bit ok;
    rst = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 16'h1234;
    bus.rd_prdy = 1'b1;

    // 1: reset and idle
    repeat (2) @(negedge clk);
    chk("rst_ram_strobes", {29'h0, ram_we, ram_re, ram_ore}, 0);
    chk("rst_byp_sel", {31'h0, ram_byp_sel}, 0);
    tick();
    rst = 1'b0;
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("idle_wr_prdy", {31'h0, bus.wr_prdy}, 1);
    chk("idle_rd_pvld", {31'h0, bus.rd_pvld}, 0);
    chk("idle_cnt", {27'h0, cnt}, 0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_we || ram_re || ram_ore) pulses++;
    end
    chk("idle_no_pulses", pulses, 0);

    // 2: single-word latency
    tick();
    r0 = rd_cnt;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 16'hA5A5;
    @(negedge clk);
    chk("t2_wr_prdy", {31'h0, bus.wr_prdy}, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.wr_pvld = 1'b0;
      @(negedge clk);
      n++;
      if (bus.rd_pvld) break;
    end
    chk("t2_latency", n, LAT);
    chk("t2_rd_pd", {16'h0, bus.rd_pd}, 32'hA5A5);
    drain();
    chk("t2_one_beat", rd_cnt - r0, 1);

    // 3: capacity and gap-free drain
    fill(acc);
    chk("t3_accepted", acc, CAP);
    @(negedge clk);
    chk("t3_cnt_full", {27'h0, cnt}, 20);
    chk("t3_wr_prdy_low", {31'h0, bus.wr_prdy}, 0);
    tick();
    bus.rd_prdy = 1'b1;
    gaps = 0;
    repeat (CAP) begin
      @(negedge clk);
      if (!bus.rd_pvld) gaps++;
    end
    chk("t3_no_gaps", gaps, 0);
    drain();

    // 4: streaming with rd_prdy toggling every cycle
    stream(100, 1'b1);
    drain();

    // 5: full FIFO with simultaneous push and pop
    fill(acc);
    chk("t5_accepted", acc, CAP);
    stream(60, 1'b0);
    drain();

    // 6: mid-operation reset discards buffered words
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) write_word(16'h0100 + 16'(i), ok);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rd_pvld", {31'h0, bus.rd_pvld}, 0);
    chk("t6_cnt", {27'h0, cnt}, 0);
    chk("t6_wr_prdy", {31'h0, bus.wr_prdy}, 1);
    tick();
    r0 = rd_cnt;
    write_word(16'h0001, ok);
    chk("t6_write_ok", {31'h0, ok}, 1);
    drain();
    repeat (5) tick();
    chk("t6_single_read", rd_cnt - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
